fpmul_req: RTL and testbench
============================

# fpmul_req

Requester-side sequencer for the floating-point multiplier. Accepts IEEE-754 single-precision operand pairs over a valid/ready input channel and drives the multiplier's `Start`/operand inputs. Waits for `Done`, captures the product and exception flags, and presents them on a valid/ready output channel. It sits between the datapath/host fabric and the multiplier, and adds a watchdog that recovers the multiplier if `Done` never arrives.

## Interface
- `TIMEOUT`, 32: cycles allowed in ISSUE before abort. Must be ≥ 16, since the multiplier worst case is 10 cycles.
- `CNT_W`, 16: width of the completed-operation counter.
- `clk` in 1: clock. One clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: block can accept an operand pair.
- `in_a`, `in_b` in 32: operands A and B.
- `mul_start` out 1: `Start` to the multiplier control unit.
- `mul_rst` out 1: one-cycle reset pulse to the multiplier, issued on timeout.
- `mul_a`, `mul_b` out 32: operands driven to the multiplier's A/B registers.
- `mul_done` in 1: `Done` from the multiplier.
- `mul_p` in 32: packed product.
- `mul_uf`, `mul_of`, `mul_nan`, `mul_inf`, `mul_zf` in 1: result flags.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_p` out 32: product.
- `out_flags` out 6: {timeout, zf, inf, nan, of, uf}.
- `busy` out 1: state ≠ IDLE.
- `op_count` out `CNT_W`: results accepted since reset; wraps modulo 2^`CNT_W`.

## Operation
- States:
  - IDLE: waiting for an operand pair.
  - ISSUE: `mul_start` held high, waiting for `mul_done`.
  - HOLD: result presented on the output channel.
- `in_ready` = IDLE | (HOLD & `out_ready`).
  - An input handshake latches `in_a`/`in_b` into operand registers and moves to ISSUE.
  - From HOLD, the output and input handshakes complete in the same cycle (back-to-back).
- ISSUE behaviour:
  - `mul_start` = 1 for the whole state.
  - `mul_a`/`mul_b` are held constant from the operand registers; they change only on an input handshake.
  - Start is held, not pulsed, because the multiplier samples it only in its wait state and spends one cycle in its reset state after each `Done`.
- ISSUE & `mul_done`:
  - Capture `out_p` ← `mul_p`.
  - Capture `out_flags` ← {0, `mul_zf`, `mul_inf`, `mul_nan`, `mul_of`, `mul_uf`}.
  - Move to HOLD. `mul_start` is 0 in the following cycle.
- Watchdog:
  - Counts cycles in ISSUE and clears on entry.
  - If it reaches `TIMEOUT`−1 without `mul_done`: `out_p` ← 0x7FC00000, `out_flags` ← 6'b100000, `mul_rst` = 1 for that one cycle, next state HOLD.
- HOLD & `out_ready`:
  - `op_count` += 1.
  - Next state is ISSUE if `in_valid`, else IDLE.
- `mul_done` outside ISSUE is ignored. A same-cycle timeout and `mul_done` resolves as done (timeout loses).
- Reset mid-operation:
  - All state clears and a pending result is discarded.
  - `mul_rst` is not asserted by `rst`; the system reset drives the multiplier directly.

## Timing
- Reset values:
  - State IDLE.
  - `in_ready` = 1.
  - `mul_start`, `mul_rst`, `out_valid`, `busy` = 0.
  - `out_p`, `out_flags`, `mul_a`, `mul_b`, `op_count` = 0.
  - Watchdog = 0.
- Input handshake at edge N → `mul_start` = 1 and `busy` = 1 from cycle N+1.
- `mul_done` sampled at edge M → `out_valid` = 1 and `mul_start` = 0 in cycle M+1.
- Latency: input handshake to `out_valid` = multiplier latency + 1 cycle.
- Outputs are registered except `in_ready` and `busy`, which decode combinationally from state and `out_ready`.
- `out_p`/`out_flags` are stable while `out_valid` & !`out_ready`.

## Structure
- Shared `fpmul_pkg`:
  - State encoding (2 bits).
  - Flag bit indices: UF=0, OF=1, NAN=2, INF=3, ZF=4, TO=5.
  - Constant `QNAN` = 32'h7FC00000.
- No sub-module. The watchdog counter (width clog2(`TIMEOUT`)) and the FSM live in `fpmul_req`; the bench instantiates it with the real multiplier or a behavioural model.

## Test plan
- 0x40000000 × 0x40400000 (2.0×3.0) with `out_ready` = 1 → `out_p` = 0x40C00000, `out_flags` = 0, `op_count` = 1, `mul_start` high exactly until the cycle after `mul_done`.
- 0x7F800000 × 0x00000000 then 0x7F000000 × 0x7F000000 back-to-back with `in_valid` held → flags NAN then OF/INF as reported by the multiplier; no idle cycle between HOLD and the second ISSUE.
- `out_ready` = 0 for 5 cycles after a result → `out_valid`/`out_p` held constant, `in_ready` = 0, a second operand pair is not accepted until the output handshake.
- Model never asserts Done → after 32 ISSUE cycles `mul_rst` pulses once, `out_p` = 0x7FC00000, `out_flags` = 6'b100000; a later stray `mul_done` in IDLE has no effect.
- Assert `rst` during ISSUE → `out_valid` = 0, `mul_start` = 0 asynchronously; after release the next op completes normally.
- `CNT_W` = 4: complete 17 ops → `op_count` = 1 (wrap).

Source files
------------

// File: rtl/fpmul_pkg.sv
// Shared definitions for the floating-point multiplier requester:
// FSM state encoding, result flag bit positions and the canonical quiet NaN.
package fpmul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam int FLAG_UF  = 0;
  localparam int FLAG_OF  = 1;
  localparam int FLAG_NAN = 2;
  localparam int FLAG_INF = 3;
  localparam int FLAG_ZF  = 4;
  localparam int FLAG_TO  = 5;

  localparam logic [31:0] QNAN = 32'h7FC00000;

endpackage

// File: rtl/fpmul_req.sv
// Requester-side sequencer for the FP multiplier: valid/ready operand intake,
// held Start, result capture onto a valid/ready output, and a Done watchdog.
module fpmul_req
  import fpmul_pkg::*;
#(
  parameter int TIMEOUT = 32,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  output logic             mul_start,
  output logic             mul_rst,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  input  logic             mul_done,
  input  logic [31:0]      mul_p,
  input  logic             mul_uf,
  input  logic             mul_of,
  input  logic             mul_nan,
  input  logic             mul_inf,
  input  logic             mul_zf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_p,
  output logic [5:0]       out_flags,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam int WD_W = $clog2(TIMEOUT);

  state_t          state;
  state_t          next_state;
  logic [WD_W-1:0] wd_cnt;
  logic            in_fire;
  logic            out_fire;
  logic            done_hit;
  logic            to_hit;
  logic [5:0]      mul_flags;

  // A same-cycle Done wins over the watchdog, so to_hit requires !mul_done.
  assign in_fire  = in_valid & in_ready;
  assign out_fire = (state == ST_HOLD) & out_ready;
  assign done_hit = (state == ST_ISSUE) & mul_done;
  assign to_hit   = (state == ST_ISSUE) & ~mul_done & (wd_cnt == WD_W'(TIMEOUT - 1));

  always_comb begin
    mul_flags           = '0;
    mul_flags[FLAG_UF]  = mul_uf;
    mul_flags[FLAG_OF]  = mul_of;
    mul_flags[FLAG_NAN] = mul_nan;
    mul_flags[FLAG_INF] = mul_inf;
    mul_flags[FLAG_ZF]  = mul_zf;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    busy       = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (done_hit || to_hit) next_state = ST_HOLD;
      end
      ST_HOLD: begin
        in_ready = out_ready;
        if (out_ready) next_state = in_valid ? ST_ISSUE : ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Start is held for the whole ISSUE stay; the multiplier only samples it in its wait state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      mul_start <= 1'b0;
      mul_rst   <= 1'b0;
      out_valid <= 1'b0;
      wd_cnt    <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      out_p     <= '0;
      out_flags <= '0;
      op_count  <= '0;
    end else begin
      state     <= next_state;
      mul_start <= (next_state == ST_ISSUE);
      out_valid <= (next_state == ST_HOLD);
      mul_rst   <= to_hit;
      wd_cnt    <= ((state == ST_ISSUE) && (next_state == ST_ISSUE)) ? wd_cnt + WD_W'(1) : '0;
      if (in_fire) begin
        mul_a <= in_a;
        mul_b <= in_b;
      end
      if (done_hit) begin
        out_p     <= mul_p;
        out_flags <= mul_flags;
      end else if (to_hit) begin
        out_p     <= QNAN;
        out_flags <= 6'b100000;
      end
      if (out_fire) op_count <= op_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fpmul_req.sv
// Directed bench for fpmul_req: the bench itself plays the multiplier, replying
// with hand-computed products after a chosen latency.
module tb_fpmul_req;
  import fpmul_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic        mul_start, mul_rst;
  logic [31:0] mul_a, mul_b;
  logic        mul_done;
  logic [31:0] mul_p;
  logic        mul_uf, mul_of, mul_nan, mul_inf, mul_zf;
  logic        out_valid, out_ready;
  logic [31:0] out_p;
  logic [5:0]  out_flags;
  logic        busy;
  logic [3:0]  op_count;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_count = '0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p;
    logic [4:0]  mflags;
    int          lat;
    logic [5:0]  exp_flags;
  } vec_t;

  vec_t vecs[5];

  fpmul_req #(.TIMEOUT(32), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_start(mul_start), .mul_rst(mul_rst), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_p(mul_p),
    .mul_uf(mul_uf), .mul_of(mul_of), .mul_nan(mul_nan), .mul_inf(mul_inf), .mul_zf(mul_zf),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .out_flags(out_flags),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic waitInReady();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("in_ready_wait", {31'b0, in_ready}, 32'd1);
  endtask

  // Plays the multiplier after the handshake: holds off Done for lat-1 cycles, then replies.
  task automatic finishOp(input vec_t v);
    for (int i = 1; i < v.lat; i++) begin
      @(posedge clk); #1;
      checkOutput("start_held", {31'b0, mul_start}, 32'd1);
    end
    mul_done = 1'b1;
    mul_p    = v.p;
    {mul_zf, mul_inf, mul_nan, mul_of, mul_uf} = v.mflags;
    @(posedge clk); #1;
    mul_done = 1'b0;
    mul_p    = $urandom;
    {mul_zf, mul_inf, mul_nan, mul_of, mul_uf} = 5'b11111;
    checkOutput("out_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("start_dropped", {31'b0, mul_start}, 32'd0);
    checkOutput("out_p", out_p, v.p);
    checkOutput("out_flags", {26'b0, out_flags}, {26'b0, v.exp_flags});
    checkOutput("mul_rst_quiet", {31'b0, mul_rst}, 32'd0);
  endtask

  task automatic applyStimulus(input vec_t v);
    waitInReady();
    in_valid = 1'b1;
    in_a     = v.a;
    in_b     = v.b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("start_after_hs", {31'b0, mul_start}, 32'd1);
    checkOutput("busy_issue", {31'b0, busy}, 32'd1);
    checkOutput("mul_a", mul_a, v.a);
    checkOutput("mul_b", mul_b, v.b);
    finishOp(v);
  endtask

  task automatic releaseOutput();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    exp_count++;
    checkOutput("op_count", {28'b0, op_count}, {28'b0, exp_count});
    checkOutput("out_valid_clear", {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    int cnt, n, pulses;
    vecs[0] = '{32'h40000000, 32'h40400000, 32'h40C00000, 5'b00000, 3,  6'b000000};
    vecs[1] = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 5'b00100, 4,  6'b000100};
    vecs[2] = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 5'b01010, 10, 6'b001010};
    vecs[3] = '{32'h00000000, 32'h40A00000, 32'h00000000, 5'b10000, 1,  6'b010000};
    vecs[4] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 5'b00000, 2,  6'b000000};

    rst = 1'b1; in_valid = 0; in_a = 0; in_b = 0; mul_done = 0; mul_p = 0;
    {mul_zf, mul_inf, mul_nan, mul_of, mul_uf} = 5'b0; out_ready = 0;
    #1;
    checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("rst_start", {31'b0, mul_start}, 32'd0);
    checkOutput("rst_mul_rst", {31'b0, mul_rst}, 32'd0);
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_out_p", out_p, 32'd0);
    checkOutput("rst_flags", {26'b0, out_flags}, 32'd0);
    checkOutput("rst_mul_a", mul_a, 32'd0);
    checkOutput("rst_op_count", {28'b0, op_count}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // Table of single operations
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i]);
      releaseOutput();
    end

    // Back-to-back: second pair accepted in the same cycle the first result leaves
    applyStimulus(vecs[1]);
    in_valid = 1'b1; in_a = vecs[2].a; in_b = vecs[2].b; out_ready = 1'b1;
    #1;
    checkOutput("b2b_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0; exp_count++;
    checkOutput("b2b_op_count", {28'b0, op_count}, {28'b0, exp_count});
    checkOutput("b2b_start", {31'b0, mul_start}, 32'd1);
    checkOutput("b2b_busy", {31'b0, busy}, 32'd1);
    checkOutput("b2b_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("b2b_mul_a", mul_a, vecs[2].a);
    finishOp(vecs[2]);
    releaseOutput();

    // Output stall: result held, new pair refused until the output handshake
    applyStimulus(vecs[0]);
    in_valid = 1'b1; in_a = vecs[4].a; in_b = 32'h40400000;
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("stall_in_ready", {31'b0, in_ready}, 32'd0);
      @(posedge clk); #1;
      checkOutput("stall_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("stall_out_p", out_p, vecs[0].p);
      checkOutput("stall_mul_a", mul_a, vecs[0].a);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0; exp_count++;
    checkOutput("stall_op_count", {28'b0, op_count}, {28'b0, exp_count});
    checkOutput("stall_new_a", mul_a, vecs[4].a);
    checkOutput("stall_new_b", mul_b, 32'h40400000);
    finishOp('{vecs[4].a, 32'h40400000, 32'h40400000, 5'b00000, 2, 6'b000000});
    releaseOutput();

    // Done on the last watchdog cycle resolves as a normal completion
    applyStimulus('{vecs[1].a, vecs[1].b, vecs[1].p, vecs[1].mflags, 32, vecs[1].exp_flags});
    releaseOutput();

    // Watchdog timeout with no Done at all
    waitInReady();
    in_valid = 1'b1; in_a = vecs[0].a; in_b = vecs[0].b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cnt = 0; n = 0; pulses = 0;
    while (!out_valid && n < 60) begin
      if (mul_start) cnt++;
      if (mul_rst) pulses++;
      @(posedge clk); #1;
      n++;
    end
    checkOutput("to_issue_cycles", cnt, 32);
    checkOutput("to_out_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("to_mul_rst", {31'b0, mul_rst}, 32'd1);
    checkOutput("to_out_p", out_p, QNAN);
    checkOutput("to_flags", {26'b0, out_flags}, 32'h20);
    checkOutput("to_start", {31'b0, mul_start}, 32'd0);
    @(posedge clk); #1;
    checkOutput("to_mul_rst_once", {31'b0, mul_rst}, 32'd0);
    checkOutput("to_rst_early", pulses, 0);
    releaseOutput();
    mul_done = 1'b1; mul_p = 32'h12345678;
    @(posedge clk); #1;
    mul_done = 1'b0;
    checkOutput("stray_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("stray_busy", {31'b0, busy}, 32'd0);
    checkOutput("stray_start", {31'b0, mul_start}, 32'd0);
    checkOutput("stray_out_p", out_p, QNAN);

    // Asynchronous reset in the middle of ISSUE
    waitInReady();
    in_valid = 1'b1; in_a = vecs[2].a; in_b = vecs[2].b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("arst_start", {31'b0, mul_start}, 32'd0);
    checkOutput("arst_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("arst_busy", {31'b0, busy}, 32'd0);
    checkOutput("arst_mul_rst", {31'b0, mul_rst}, 32'd0);
    checkOutput("arst_op_count", {28'b0, op_count}, 32'd0);
    exp_count = '0;
    @(posedge clk); #1 rst = 1'b0;

    // 17 operations after reset: counter wraps through 16 back to 1
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i % 5]);
      releaseOutput();
    end
    checkOutput("wrap_op_count", {28'b0, op_count}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got hang expected finish");
    $fatal(1, "[TB] simulation time limit");
  end

endmodule
